// File: rtl/xbar_pkg.sv
// Shared types and helpers for the stream crossbar arbiter.
package xbar_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Index width for n items, never below one bit so single-entry ports stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_s.sv
// Single-output round-robin arbiter that locks its grant for a whole packet.
module rr_arb_s
    import xbar_pkg::*;
#(
    parameter int S_COUNT = 2
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [S_COUNT-1:0] req_i,
    input  logic [S_COUNT-1:0] s_valid_i,
    input  logic [S_COUNT-1:0] s_last_i,
    input  logic               m_ready_i,
    output logic [S_COUNT-1:0] grant_o,
    output logic               busy_o
);

    localparam int PW = idx_width(S_COUNT);

    arb_state_t           state_q, state_d;
    logic [S_COUNT-1:0]   grant_q, grant_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic                 xfer_last;
    logic                 found;
    logic [2*S_COUNT-1:0] req_dbl;
    logic [S_COUNT-1:0]   req_rot;
    logic [S_COUNT-1:0]   gnt_rot;
    logic [2*S_COUNT-1:0] gnt_dbl;

    // The packet ends when the granted source moves its last beat into the sink.
    assign xfer_last = m_ready_i && |(grant_q & s_valid_i & s_last_i);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        found   = 1'b0;
        gnt_rot = '0;
        // Rotate requests so that bit 0 is the source at the pointer.
        req_dbl = {req_i, req_i} >> ptr_q;
        req_rot = req_dbl[S_COUNT-1:0];
        for (int i = 0; i < S_COUNT; i++) begin
            if (!found && req_rot[i]) begin
                found      = 1'b1;
                gnt_rot[i] = 1'b1;
            end
        end
        gnt_dbl = {gnt_rot, gnt_rot} << ptr_q;

        case (state_q)
            ARB_IDLE: begin
                if (found) begin
                    grant_d = gnt_dbl[2*S_COUNT-1:S_COUNT];
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (xfer_last) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    for (int i = 0; i < S_COUNT; i++) begin
                        if (grant_q[i]) begin
                            ptr_d = (i == S_COUNT - 1) ? '0 : PW'(i + 1);
                        end
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == ARB_BUSY);

endmodule

// File: rtl/xbar_arbiter.sv
// Per-output packet arbiter driving crossbar mux selects and source ready.
// Handshake: a beat moves when s_valid_i[s] && s_ready_o[s]; ready never depends on valid.
module xbar_arbiter
    import xbar_pkg::*;
#(
    parameter  int S_DATA_COUNT = 2,
    parameter  int M_DATA_COUNT = 3,
    localparam int T_DEST_WIDTH = idx_width(M_DATA_COUNT)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic [S_DATA_COUNT*T_DEST_WIDTH-1:0] s_dest_i,
    input  logic [S_DATA_COUNT-1:0]              s_valid_i,
    input  logic [S_DATA_COUNT-1:0]              s_last_i,
    input  logic [M_DATA_COUNT-1:0]              m_ready_i,
    output logic [M_DATA_COUNT*S_DATA_COUNT-1:0] req_o,
    output logic [S_DATA_COUNT-1:0]              s_ready_o
);

    localparam logic [T_DEST_WIDTH:0] M_LIMIT = (T_DEST_WIDTH + 1)'(M_DATA_COUNT);

    logic [S_DATA_COUNT-1:0] grant   [M_DATA_COUNT];
    logic [S_DATA_COUNT-1:0] req_vec [M_DATA_COUNT];
    logic [M_DATA_COUNT-1:0] busy;
    logic [S_DATA_COUNT-1:0] held;
    logic [S_DATA_COUNT-1:0] sink;
    logic [T_DEST_WIDTH:0]   dest_ext;

    always_comb begin
        held     = '0;
        sink     = '0;
        dest_ext = '0;
        for (int o = 0; o < M_DATA_COUNT; o++) begin
            req_vec[o] = '0;
            held       = held | grant[o];
        end
        // Destination only matters for sources not already locked to an output.
        for (int s = 0; s < S_DATA_COUNT; s++) begin
            dest_ext = {1'b0, s_dest_i[s*T_DEST_WIDTH +: T_DEST_WIDTH]};
            sink[s]  = rst_n_i && !held[s] && (dest_ext >= M_LIMIT);
            for (int o = 0; o < M_DATA_COUNT; o++) begin
                req_vec[o][s] = s_valid_i[s] && !held[s] &&
                                (dest_ext == (T_DEST_WIDTH + 1)'(o));
            end
        end
    end

    always_comb begin
        s_ready_o = sink;
        req_o     = '0;
        for (int o = 0; o < M_DATA_COUNT; o++) begin
            req_o[o*S_DATA_COUNT +: S_DATA_COUNT] = grant[o];
            s_ready_o = s_ready_o | (grant[o] & {S_DATA_COUNT{busy[o] & m_ready_i[o]}});
        end
    end

    for (genvar o = 0; o < M_DATA_COUNT; o++) begin : g_arb
        rr_arb_s #(
            .S_COUNT(S_DATA_COUNT)
        ) u_arb (
            .clk_i    (clk_i),
            .rst_n_i  (rst_n_i),
            .req_i    (req_vec[o]),
            .s_valid_i(s_valid_i),
            .s_last_i (s_last_i),
            .m_ready_i(m_ready_i[o]),
            .grant_o  (grant[o]),
            .busy_o   (busy[o])
        );
    end

endmodule

// File: tb/tb_xbar_arbiter.sv
// Bench for xbar_arbiter with 2 sources and 3 outputs: directed steps, then random traffic.
module tb_xbar_arbiter;

    localparam int S = 2;
    localparam int M = 3;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic [1:0] dest_v [S];
    logic [3:0] s_dest_i;
    logic [1:0] s_valid_i;
    logic [1:0] s_last_i;
    logic [2:0] m_ready_i;
    logic [5:0] req_o;
    logic [1:0] s_ready_o;

    // Reference: which source owns each output (-1 when free) and its round-robin start.
    int owner [M];
    int ptr   [M];
    int errors = 0;
    int checks = 0;

    assign s_dest_i = {dest_v[1], dest_v[0]};

    always #5 clk_i = ~clk_i;

    xbar_arbiter #(
        .S_DATA_COUNT(S),
        .M_DATA_COUNT(M)
    ) dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .s_dest_i (s_dest_i),
        .s_valid_i(s_valid_i),
        .s_last_i (s_last_i),
        .m_ready_i(m_ready_i),
        .req_o    (req_o),
        .s_ready_o(s_ready_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit owned(input int s);
        for (int o = 0; o < M; o++) begin
            if (owner[o] == s) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [1:0] req_of(input int o);
        return req_o[o*2 +: 2];
    endfunction

    task automatic model_out(output logic [5:0] er, output logic [1:0] ed);
        er = '0;
        ed = '0;
        for (int o = 0; o < M; o++) begin
            if (owner[o] >= 0) begin
                er = er | (6'(1) << (o * 2 + owner[o]));
                if (m_ready_i[o]) ed = ed | (2'(1) << owner[o]);
            end
        end
        for (int s = 0; s < S; s++) begin
            if (rst_n_i && dest_v[s] == 2'd3 && !owned(s)) ed = ed | (2'(1) << s);
        end
    endtask

    task automatic model_tick();
        bit held [S];
        bit found;
        int s;
        if (!rst_n_i) begin
            for (int o = 0; o < M; o++) begin
                owner[o] = -1;
                ptr[o]   = 0;
            end
        end else begin
            for (int k = 0; k < S; k++) held[k] = owned(k);
            for (int o = 0; o < M; o++) begin
                if (owner[o] >= 0) begin
                    s = owner[o];
                    if (s_valid_i[s] && m_ready_i[o] && s_last_i[s]) begin
                        owner[o] = -1;
                        ptr[o]   = (s + 1) % S;
                    end
                end else begin
                    found = 1'b0;
                    for (int k = 0; k < S; k++) begin
                        s = (ptr[o] + k) % S;
                        if (!found && s_valid_i[s] && int'(dest_v[s]) == o && !held[s]) begin
                            owner[o] = s;
                            found    = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    // One clock: compare against the reference mid-cycle, then advance it at the edge.
    task automatic step();
        logic [5:0] er;
        logic [1:0] ed;
        @(negedge clk_i);
        model_out(er, ed);
        chk("req_o", {26'b0, req_o}, {26'b0, er});
        chk("s_ready_o", {30'b0, s_ready_o}, {30'b0, ed});
        @(posedge clk_i);
        model_tick();
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] d0, input logic [1:0] d1,
                         input logic [1:0] l, input logic [2:0] mr);
        s_valid_i = v;
        dest_v[0] = d0;
        dest_v[1] = d1;
        s_last_i  = l;
        m_ready_i = mr;
    endtask

    initial begin
        for (int o = 0; o < M; o++) begin
            owner[o] = -1;
            ptr[o]   = 0;
        end

        // Reset held with both sources valid
        rst_n_i = 1'b0;
        drive(2'b11, 2'd1, 2'd1, 2'b00, 3'b111);
        @(posedge clk_i);
        model_tick();
        #1;
        step();
        step();
        chk("rst_req", {26'b0, req_o}, 32'h0);
        chk("rst_rdy", {30'b0, s_ready_o}, 32'h0);
        rst_n_i = 1'b1;
        step();
        chk("grant_after_reset", {30'b0, req_of(1)}, 32'h1);
        drive(2'b11, 2'd1, 2'd1, 2'b01, 3'b111);
        step();
        chk("release_src0", {30'b0, req_of(1)}, 32'h0);
        drive(2'b11, 2'd1, 2'd1, 2'b00, 3'b111);
        step();
        chk("rr_second", {30'b0, req_of(1)}, 32'h2);
        drive(2'b00, 2'd1, 2'd1, 2'b00, 3'b111);
        step();
        chk("hold_no_valid", {30'b0, req_of(1)}, 32'h2);
        drive(2'b10, 2'd1, 2'd1, 2'b10, 3'b111);
        step();
        chk("release_src1", {30'b0, req_of(1)}, 32'h0);

        // Contention on output 2 with 3-beat packets
        drive(2'b11, 2'd2, 2'd2, 2'b00, 3'b111);
        step();
        chk("cont_src0", {30'b0, req_of(2)}, 32'h1);
        step();
        step();
        drive(2'b11, 2'd2, 2'd2, 2'b01, 3'b111);
        step();
        chk("cont_bubble", {30'b0, req_of(2)}, 32'h0);
        drive(2'b11, 2'd2, 2'd2, 2'b00, 3'b111);
        step();
        chk("cont_src1", {30'b0, req_of(2)}, 32'h2);
        step();
        step();
        drive(2'b11, 2'd2, 2'd2, 2'b10, 3'b111);
        step();
        chk("cont_rel1", {30'b0, req_of(2)}, 32'h0);
        drive(2'b11, 2'd2, 2'd2, 2'b00, 3'b111);
        step();
        chk("cont_round2", {30'b0, req_of(2)}, 32'h1);
        drive(2'b11, 2'd2, 2'd2, 2'b01, 3'b111);
        step();
        drive(2'b00, 2'd2, 2'd2, 2'b00, 3'b111);
        step();

        // Backpressure on output 0
        drive(2'b01, 2'd0, 2'd2, 2'b00, 3'b111);
        step();
        chk("bp_grant", {30'b0, req_of(0)}, 32'h1);
        #1 chk("bp_rdy_a", {31'b0, s_ready_o[0]}, 32'h1);
        step();
        drive(2'b01, 2'd0, 2'd2, 2'b01, 3'b110);
        #1 chk("bp_rdy_b", {31'b0, s_ready_o[0]}, 32'h0);
        step();
        chk("bp_hold1", {30'b0, req_of(0)}, 32'h1);
        step();
        chk("bp_hold2", {30'b0, req_of(0)}, 32'h1);
        drive(2'b01, 2'd0, 2'd2, 2'b01, 3'b111);
        #1 chk("bp_rdy_c", {31'b0, s_ready_o[0]}, 32'h1);
        step();
        chk("bp_release", {30'b0, req_of(0)}, 32'h0);
        drive(2'b00, 2'd0, 2'd2, 2'b00, 3'b111);
        step();

        // Parallel grants on outputs 0 and 2
        drive(2'b11, 2'd0, 2'd2, 2'b00, 3'b111);
        step();
        chk("parallel", {26'b0, req_o}, 32'h21);
        drive(2'b11, 2'd0, 2'd2, 2'b11, 3'b111);
        step();
        drive(2'b00, 2'd0, 2'd2, 2'b00, 3'b111);
        step();

        // Destination change mid-packet
        drive(2'b10, 2'd0, 2'd1, 2'b00, 3'b111);
        step();
        chk("dchg_grant", {30'b0, req_of(1)}, 32'h2);
        step();
        drive(2'b10, 2'd0, 2'd0, 2'b00, 3'b111);
        step();
        chk("dchg_out0", {30'b0, req_of(0)}, 32'h0);
        chk("dchg_hold", {30'b0, req_of(1)}, 32'h2);
        drive(2'b10, 2'd0, 2'd0, 2'b10, 3'b111);
        step();
        chk("dchg_rel", {30'b0, req_of(1)}, 32'h0);
        drive(2'b00, 2'd0, 2'd1, 2'b00, 3'b111);
        step();

        // Out-of-range destination acts as a sink
        drive(2'b01, 2'd3, 2'd1, 2'b00, 3'b111);
        #1 chk("oob_ready", {30'b0, s_ready_o}, 32'h1);
        step();
        chk("oob_noreq", {26'b0, req_o}, 32'h0);
        step();
        drive(2'b00, 2'd3, 2'd1, 2'b00, 3'b111);
        step();

        // Reset in the middle of a packet clears grants and pointers
        drive(2'b01, 2'd2, 2'd1, 2'b01, 3'b111);
        step();
        step();
        drive(2'b01, 2'd2, 2'd1, 2'b00, 3'b111);
        step();
        chk("midrst_pre", {30'b0, req_of(2)}, 32'h1);
        step();
        rst_n_i = 1'b0;
        step();
        chk("midrst_clear", {26'b0, req_o}, 32'h0);
        rst_n_i = 1'b1;
        drive(2'b11, 2'd2, 2'd2, 2'b00, 3'b111);
        step();
        chk("midrst_ptr", {30'b0, req_of(2)}, 32'h1);
        drive(2'b00, 2'd2, 2'd2, 2'b00, 3'b111);
        step();
        step();

        // Random traffic against the reference
        for (int n = 0; n < 400; n++) begin
            rst_n_i = ($urandom_range(0, 39) != 0);
            s_valid_i = 2'($urandom_range(0, 3));
            for (int s = 0; s < S; s++) begin
                dest_v[s] = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            end
            s_last_i[0] = ($urandom_range(0, 2) == 0);
            s_last_i[1] = ($urandom_range(0, 2) == 0);
            m_ready_i   = 3'($urandom_range(0, 7));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
